// File: rtl/discrete_values_table_loader.sv
// discrete_values_table_loader: write-side front end of the discrete-value range table.
// Ports:
//   in_clk, in_reset_n         clock, asynchronous active-low reset
//   in_valid / out_ready       programming stream handshake
//   in_is_header               1 = header beat {variable index, value count, last flag}
//                              0 = range-pair beat {start, end}
//   in_clear_error             leaves the ERROR state
//   out_wr_*                   range-table write port, address {variable, value index}
//   out_count_*                per-variable value-count write port
//   out_done                   one-cycle pulse when the last variable completes
//   out_error, out_error_code  sticky error (1 bad count, 2 structure, 3 start>end)
module discrete_values_table_loader #(
    parameter int VAR_IDX_W = 4,
    parameter int VAL_IDX_W = 4,
    parameter int DATA_W    = 16
) (
    input  logic                         in_clk,
    input  logic                         in_reset_n,
    input  logic                         in_valid,
    output logic                         out_ready,
    input  logic                         in_is_header,
    input  logic [VAR_IDX_W-1:0]         in_variable_index,
    input  logic [VAL_IDX_W:0]           in_value_count,
    input  logic                         in_last_variable,
    input  logic [DATA_W-1:0]            in_start_value,
    input  logic [DATA_W-1:0]            in_end_value,
    input  logic                         in_clear_error,
    output logic                         out_wr_en,
    output logic [VAR_IDX_W+VAL_IDX_W-1:0] out_wr_address,
    output logic [DATA_W-1:0]            out_wr_start,
    output logic [DATA_W-1:0]            out_wr_end,
    output logic                         out_count_wr_en,
    output logic [VAR_IDX_W-1:0]         out_count_variable_index,
    output logic [VAL_IDX_W:0]           out_count_value,
    output logic                         out_done,
    output logic                         out_error,
    output logic [1:0]                   out_error_code
);
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERROR} state_t;

    localparam logic [VAL_IDX_W:0] MAX_CNT = {1'b1, {VAL_IDX_W{1'b0}}};

    state_t                          r_state;
    state_t                          w_state_next;
    logic                            r_ready;
    logic [VAR_IDX_W-1:0]            r_var;
    logic [VAL_IDX_W:0]              r_count;
    logic                            r_last;
    logic [VAL_IDX_W:0]              r_val_cnt;
    logic                            r_wr_en;
    logic [VAR_IDX_W+VAL_IDX_W-1:0]  r_wr_address;
    logic [DATA_W-1:0]               r_wr_start;
    logic [DATA_W-1:0]               r_wr_end;
    logic                            r_count_wr_en;
    logic [VAR_IDX_W-1:0]            r_count_var;
    logic [VAL_IDX_W:0]              r_count_value;
    logic                            r_done;
    logic                            r_error;
    logic [1:0]                      r_error_code;

    logic                            w_fire;
    logic                            w_bad_count;
    logic                            w_bad_range;
    logic [VAL_IDX_W:0]              w_cnt_inc;
    logic                            w_hdr_ok;
    logic                            w_wr;
    logic                            w_cnt_wr;
    logic                            w_done;
    logic                            w_err_set;
    logic [1:0]                      w_err_code;

    assign w_fire      = in_valid && r_ready;
    assign w_bad_count = (in_value_count == '0) || (in_value_count > MAX_CNT);
    assign w_bad_range = $signed(in_start_value) > $signed(in_end_value);
    assign w_cnt_inc   = r_val_cnt + 1'b1;

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) r_state <= S_IDLE;
        else             r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_hdr_ok     = 1'b0;
        w_wr         = 1'b0;
        w_cnt_wr     = 1'b0;
        w_done       = 1'b0;
        w_err_set    = 1'b0;
        w_err_code   = 2'd0;
        case (r_state)
            S_IDLE: if (w_fire) begin
                if (!in_is_header || w_bad_count) begin
                    w_state_next = S_ERROR;
                    w_err_set    = 1'b1;
                    w_err_code   = in_is_header ? 2'd1 : 2'd2;
                end else begin
                    w_state_next = S_DATA;
                    w_hdr_ok     = 1'b1;
                end
            end
            S_DATA: if (w_fire) begin
                if (in_is_header || w_bad_range) begin
                    w_state_next = S_ERROR;
                    w_err_set    = 1'b1;
                    w_err_code   = in_is_header ? 2'd2 : 2'd3;
                end else begin
                    w_wr = 1'b1;
                    if (w_cnt_inc == r_count) begin
                        w_cnt_wr     = 1'b1;
                        w_done       = r_last;
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_ERROR: if (in_clear_error) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_ready       <= 1'b0;
            r_var         <= '0;
            r_count       <= '0;
            r_last        <= 1'b0;
            r_val_cnt     <= '0;
            r_wr_en       <= 1'b0;
            r_wr_address  <= '0;
            r_wr_start    <= '0;
            r_wr_end      <= '0;
            r_count_wr_en <= 1'b0;
            r_count_var   <= '0;
            r_count_value <= '0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_error_code  <= 2'd0;
        end else begin
            // Registered ready tracks the state being entered, so it drops on the error edge.
            r_ready       <= w_state_next != S_ERROR;
            r_wr_en       <= w_wr;
            r_count_wr_en <= w_cnt_wr;
            r_done        <= w_done;
            if (w_hdr_ok) begin
                r_var     <= in_variable_index;
                r_count   <= in_value_count;
                r_last    <= in_last_variable;
                r_val_cnt <= '0;
            end
            if (w_wr) begin
                r_wr_address <= {r_var, r_val_cnt[VAL_IDX_W-1:0]};
                r_wr_start   <= in_start_value;
                r_wr_end     <= in_end_value;
                r_val_cnt    <= w_cnt_inc;
            end
            if (w_cnt_wr) begin
                r_count_var   <= r_var;
                r_count_value <= r_count;
            end
            if (w_err_set) begin
                r_error      <= 1'b1;
                r_error_code <= w_err_code;
            end else if (r_state == S_ERROR && in_clear_error) begin
                r_error      <= 1'b0;
                r_error_code <= 2'd0;
            end
        end
    end

    assign out_ready                = r_ready;
    assign out_wr_en                = r_wr_en;
    assign out_wr_address           = r_wr_address;
    assign out_wr_start             = r_wr_start;
    assign out_wr_end               = r_wr_end;
    assign out_count_wr_en          = r_count_wr_en;
    assign out_count_variable_index = r_count_var;
    assign out_count_value          = r_count_value;
    assign out_done                 = r_done;
    assign out_error                = r_error;
    assign out_error_code           = r_error_code;
endmodule
